mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter for the single-port 1K x 16 program/data memory. It shares that memory between the processor core (port A) and the I2C program loader (port B). It grants one access per cycle, returns read data one cycle later and keeps round-robin fairness. Optionally, port B can lock the memory for a burst while the core is held off.

## Interface
Parameters:
- AW, 10, address width
- DW, 16, data width
- LOCK_MAX, 255, maximum consecutive locked grants to port B (1..255)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  core access request; a_we/a_addr/a_wdata held stable until a_gnt
- a_we  in  1  core write (1) / read (0)
- a_addr  in  AW  core address
- a_wdata  in  DW  core write data
- a_gnt  out  1  core access accepted this cycle (combinational)
- a_rvalid  out  1  core read data valid (registered)
- a_rdata  out  DW  core read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same meaning for the loader port
- b_lock  in  1  loader requests exclusive burst (LOCK feature only)
- mem_addr  out  AW  memory address (combinational from granted port, 0 if none)
- mem_wdata  out  DW  memory write data (0 if none)
- mem_we  out  1  memory write enable = gnt & we of granted port
- mem_rdata  in  DW  memory read data, valid one cycle after address
- core_hold  out  1  registered; 1 while port B holds lock
- lock_timeout  out  1  one-cycle pulse when lock forcibly ended

## Operation
- Reset values: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, rdata outputs 0, mem_* 0, core_hold=0, lock_timeout=0. State IDLE, last_winner=B, lock counter 0.
- Single request: granted the same cycle.
- Both requesting: grant the port that is not last_winner. last_winner updates on every grant.
- No request: no grant, mem_we=0, last_winner unchanged.
- Read grant in cycle N: the matching rvalid=1 in cycle N+1, with rdata=mem_rdata. The other port's rvalid stays 0.
- Write grant: no rvalid.
- rdata holds its last value when rvalid=0.
- States: IDLE (normal round robin), LOCKED, DRAIN.
  - IDLE->LOCKED when B is granted with b_lock=1. The lock counter loads 1.
  - LOCKED: a_gnt=0. B is granted whenever b_req=1, and the counter increments per B grant.
  - LOCKED->IDLE when b_lock=0 that cycle. That cycle arbitrates as IDLE.
  - LOCKED->DRAIN when the counter reaches LOCK_MAX and b_lock=1. The LOCK_MAX-th grant is the last exclusive one. Next cycle: lock_timeout=1 and normal round robin with last_winner=B.
  - DRAIN: arbitration as IDLE, but b_lock is ignored. DRAIN->IDLE once b_lock is sampled 0.
- core_hold=1 in the cycle after entering LOCKED, through the cycle that exits LOCKED.
- Synchronous rst mid-operation: all state returns to reset values next cycle. Any outstanding read produces no rvalid.
- Simultaneous events:
  - A and B request in the same cycle B releases lock: round robin picks A (last_winner=B).
  - b_lock=1 with b_req=0: no lock entry.

## Timing
- Grant latency: 0 cycles, combinational from req and state. No combinational path from mem_rdata to any gnt.
- Read latency: 1 cycle (grant cycle N, data N+1). Back-to-back reads are sustainable at 1 per cycle.
- Lock counter is 8 bits, saturating; it never wraps.
- Worst-case port A wait: LOCK_MAX+1 cycles with LOCK, 1 cycle without.

## Configuration
- MEM_ARB_LOCK_EN defined: b_lock honoured; LOCKED/DRAIN states, counter, core_hold and lock_timeout implemented as above.
- Not defined: b_lock ignored, state machine reduces to IDLE, core_hold and lock_timeout tied 0. Arbitration is pure round robin.

## Test plan
- Reset, then A read addr 0x005 with memory word 0x1234: a_gnt same cycle, mem_addr=0x005, a_rvalid=1 and a_rdata=0x1234 next cycle.
- A and B request continuously (A reads, B writes 0xBEEF): grants alternate A,B,A,B starting with A; mem_we=1 only on B cycles.
- (LOCK) B locks 4 writes to 0x100..0x103 while A requests: a_gnt=0 for 4 cycles, core_hold=1, then A granted in the cycle b_lock drops.
- (LOCK, LOCK_MAX=3) B holds b_lock=1 and b_req=1: 3 exclusive B grants, then lock_timeout=1 for one cycle with A granted. Grants alternate until b_lock is seen 0.
- Assert rst in the cycle after an A read grant: a_rvalid stays 0, all outputs 0, next request after reset granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port 1K x 16 memory between the core (A) and the I2C loader (B).
// Define MEM_ARB_LOCK_EN to let port B lock the memory for bounded exclusive bursts (LOCKED/DRAIN).
module mem_port_arbiter #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  input  logic          b_lock,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_hold,
  output logic          lock_timeout
);

  logic          last_b_q, last_b_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_gnt_c, b_gnt_c;
  logic          b_excl;

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    DRAIN
  } state_e;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  state_e     state_q, state_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       core_hold_q, core_hold_d;
  logic       lock_timeout_q, lock_timeout_d;

  assign b_excl = (state_q == LOCKED) && b_lock;
`else
  logic unused_lock;

  assign unused_lock = b_lock ^ (^8'(LOCK_MAX));
  assign b_excl      = 1'b0;
`endif

  // Grants: exclusive B while locked, otherwise round robin against the last winner.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    if (!rst) begin
      if (b_excl) begin
        b_gnt_c = b_req;
      end else if (a_req && b_req) begin
        a_gnt_c = last_b_q;
        b_gnt_c = !last_b_q;
      end else begin
        a_gnt_c = a_req;
        b_gnt_c = b_req;
      end
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (a_gnt_c) begin
      last_b_d = 1'b0;
    end else if (b_gnt_c) begin
      last_b_d = 1'b1;
    end

    a_rvalid_d = a_gnt_c && !a_we;
    b_rvalid_d = b_gnt_c && !b_we;
    a_rdata_d  = a_rvalid_q ? mem_rdata : a_rdata_q;
    b_rdata_d  = b_rvalid_q ? mem_rdata : b_rdata_q;

`ifdef MEM_ARB_LOCK_EN
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (b_gnt_c && b_lock) begin
          lock_cnt_d = 8'd1;
          if (LOCK_LIM <= 8'd1) begin
            state_d        = DRAIN;
            lock_timeout_d = 1'b1;
          end else begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!b_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (b_gnt_c) begin
          lock_cnt_d = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;
          if (lock_cnt_d >= LOCK_LIM) begin
            state_d        = DRAIN;
            lock_timeout_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!b_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
    core_hold_d = (state_d == LOCKED);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q       <= 1'b1;
      a_rvalid_q     <= 1'b0;
      b_rvalid_q     <= 1'b0;
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
`ifdef MEM_ARB_LOCK_EN
      state_q        <= IDLE;
      lock_cnt_q     <= '0;
      core_hold_q    <= 1'b0;
      lock_timeout_q <= 1'b0;
`endif
    end else begin
      last_b_q       <= last_b_d;
      a_rvalid_q     <= a_rvalid_d;
      b_rvalid_q     <= b_rvalid_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
`ifdef MEM_ARB_LOCK_EN
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      core_hold_q    <= core_hold_d;
      lock_timeout_q <= lock_timeout_d;
`endif
    end
  end

  assign a_gnt     = a_gnt_c;
  assign b_gnt     = b_gnt_c;
  assign mem_we    = (a_gnt_c && a_we) || (b_gnt_c && b_we);
  assign mem_addr  = a_gnt_c ? a_addr  : (b_gnt_c ? b_addr  : '0);
  assign mem_wdata = a_gnt_c ? a_wdata : (b_gnt_c ? b_wdata : '0);

  // rst also masks registered outputs so a read granted just before reset never shows rvalid.
  assign a_rvalid = a_rvalid_q && !rst;
  assign b_rvalid = b_rvalid_q && !rst;
  assign a_rdata  = rst ? '0 : (a_rvalid_q ? mem_rdata : a_rdata_q);
  assign b_rdata  = rst ? '0 : (b_rvalid_q ? mem_rdata : b_rdata_q);

`ifdef MEM_ARB_LOCK_EN
  assign core_hold    = core_hold_q && !rst;
  assign lock_timeout = lock_timeout_q && !rst;
`else
  assign core_hold    = 1'b0;
  assign lock_timeout = 1'b0;
`endif

endmodule
